// File: rtl/dat_sink_ctrl.sv
// Channel-switch sequencer and FWFT capture FIFO for the selector output.
// Define SINK_DROP_ON_SWITCH_EN to discard words arriving while a switch settles.
module dat_sink_ctrl #(
    parameter int DEPTH_LOG2     = 4,
    parameter int FLAG_HI_CYCLES = 2,
    parameter int SETTLE_CYCLES  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sw_req,
    input  logic [2:0]            sw_channel,
    output logic                  sw_busy,
    output logic                  sw_done,
    output logic                  sw_err,
    output logic [2:0]            cur_channel,
    output logic [2:0]            channel_choose,
    output logic                  update_flag,
    input  logic [15:0]           dat_db,
    input  logic                  dat_wren,
    output logic [15:0]           out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic                  overflow,
    input  logic                  clr_overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int MAXC  = (FLAG_HI_CYCLES > SETTLE_CYCLES) ?
                           FLAG_HI_CYCLES : SETTLE_CYCLES;
    localparam int CW    = $clog2(MAXC + 1);

    localparam logic [CW-1:0] HI_LAST = CW'(FLAG_HI_CYCLES - 1);
    localparam logic [CW-1:0] LO_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [DEPTH_LOG2:0] PTR_ONE = (DEPTH_LOG2+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FLAG_HI,
        S_FLAG_LO,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    chan_q, chan_d;
    logic [2:0]    cur_q, cur_d;
    logic          err_q, err_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            chan_q  <= 3'd0;
            cur_q   <= 3'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            chan_q  <= chan_d;
            cur_q   <= cur_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        chan_d  = chan_q;
        cur_d   = cur_q;
        err_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (sw_req) begin
                    if (sw_channel <= 3'd3) begin
                        chan_d  = sw_channel;
                        cnt_d   = '0;
                        state_d = S_FLAG_HI;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_FLAG_HI: begin
                if (cnt_q == HI_LAST) begin
                    cnt_d   = '0;
                    state_d = S_FLAG_LO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_FLAG_LO: begin
                // cur_channel becomes visible together with sw_done
                if (cnt_q == LO_LAST) begin
                    cnt_d   = '0;
                    cur_d   = chan_q;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign sw_busy        = (state_q != S_IDLE);
    assign sw_done        = (state_q == S_DONE);
    assign update_flag    = (state_q == S_FLAG_HI);
    assign sw_err         = err_q;
    assign cur_channel    = cur_q;
    assign channel_choose = chan_q;

    logic [15:0]         mem_q [DEPTH];
    logic [DEPTH_LOG2:0] wptr_q, wptr_d;
    logic [DEPTH_LOG2:0] rptr_q, rptr_d;
    logic                ovf_q, ovf_d;
    logic                empty;
    logic                full;
    logic                wr_ok;
    logic                push;
    logic                pop;
    logic                drop;

`ifdef SINK_DROP_ON_SWITCH_EN
    assign wr_ok = dat_wren &&
                   (state_q != S_FLAG_LO) &&
                   (state_q != S_DONE);
`else
    assign wr_ok = dat_wren;
`endif

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[DEPTH_LOG2] != rptr_q[DEPTH_LOG2]) &&
                   (wptr_q[DEPTH_LOG2-1:0] == rptr_q[DEPTH_LOG2-1:0]);

    assign pop  = !empty && out_ready;
    assign push = wr_ok && (!full || pop);
    assign drop = wr_ok && full && !pop;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        ovf_d  = ovf_q;
        if (push) wptr_d = wptr_q + PTR_ONE;
        if (pop)  rptr_d = rptr_q + PTR_ONE;
        if (drop)
            ovf_d = 1'b1;
        else if (clr_overflow)
            ovf_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            ovf_q  <= ovf_d;
        end
    end

    // At full with a pop, the write slot is the head being popped this edge
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q[DEPTH_LOG2-1:0]] <= dat_db;
    end

    assign out_valid  = !empty;
    assign out_data   = empty ? 16'h0000 : mem_q[rptr_q[DEPTH_LOG2-1:0]];
    assign fifo_level = wptr_q - rptr_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_dat_sink_ctrl.sv
// Scoreboard bench for dat_sink_ctrl: directed switch and FIFO vectors,
// FIFO output checked by an independent monitor.
module tb_dat_sink_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sw_req = 1'b0;
    logic [2:0]  sw_channel = 3'd0;
    logic        sw_busy;
    logic        sw_done;
    logic        sw_err;
    logic [2:0]  cur_channel;
    logic [2:0]  channel_choose;
    logic        update_flag;
    logic [15:0] dat_db = 16'h0;
    logic        dat_wren = 1'b0;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  fifo_level;
    logic        overflow;
    logic        clr_overflow = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] sb[$];

    always #5 clk = ~clk;

    dat_sink_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .sw_req         (sw_req),
        .sw_channel     (sw_channel),
        .sw_busy        (sw_busy),
        .sw_done        (sw_done),
        .sw_err         (sw_err),
        .cur_channel    (cur_channel),
        .channel_choose (channel_choose),
        .update_flag    (update_flag),
        .dat_db         (dat_db),
        .dat_wren       (dat_wren),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .fifo_level     (fifo_level),
        .overflow       (overflow),
        .clr_overflow   (clr_overflow)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted head word is compared against the scoreboard
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_errors++;
                $display("FAIL fifo_pop: got %h expected no word", out_data);
            end else begin
                logic [15:0] e;
                e = sb.pop_front();
                if (out_data !== e) begin
                    n_errors++;
                    $display("FAIL fifo_data: got %h expected %h", out_data, e);
                end
            end
        end
    end

    task automatic push_word(input logic [15:0] w, input bit expect_in);
        dat_db   = w;
        dat_wren = 1'b1;
        if (expect_in) sb.push_back(w);
    endtask

    task automatic drain(input string nm);
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (fifo_level == 0) break;
            tick();
        end
        out_ready = 1'b0;
        chk({nm, "_level"}, 32'(fifo_level), 32'd0);
        chk({nm, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_done(input string nm);
        for (int i = 0; i < 30; i++) begin
            tick();
            if (sw_done) break;
        end
        chk(nm, 32'(sw_done), 32'd1);
    endtask

    initial begin
        bit drop_en;
`ifdef SINK_DROP_ON_SWITCH_EN
        drop_en = 1'b1;
`else
        drop_en = 1'b0;
`endif
        repeat (3) tick();
        chk("rst_update_flag", 32'(update_flag), 32'd0);
        chk("rst_busy", 32'(sw_busy), 32'd0);
        chk("rst_done", 32'(sw_done), 32'd0);
        chk("rst_err", 32'(sw_err), 32'd0);
        chk("rst_cur", 32'(cur_channel), 32'd0);
        chk("rst_choose", 32'(channel_choose), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Switch to channel 2: flag high 2 cycles, done 7 cycles after sampling
        sw_channel = 3'd2;
        sw_req     = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            sw_req = 1'b0;
            chk($sformatf("sw_flag_c%0d", i), 32'(update_flag),
                32'(i == 1 || i == 2));
            chk($sformatf("sw_done_c%0d", i), 32'(sw_done), 32'(i == 7));
            chk($sformatf("sw_busy_c%0d", i), 32'(sw_busy), 32'(i <= 7));
            if (i == 1) chk("sw_choose", 32'(channel_choose), 32'd2);
        end
        chk("sw_cur2", 32'(cur_channel), 32'd2);

        // Illegal channel
        sw_channel = 3'd5;
        sw_req     = 1'b1;
        tick();
        sw_req = 1'b0;
        chk("err_pulse", 32'(sw_err), 32'd1);
        chk("err_flag", 32'(update_flag), 32'd0);
        chk("err_busy", 32'(sw_busy), 32'd0);
        tick();
        chk("err_clear", 32'(sw_err), 32'd0);
        chk("err_cur", 32'(cur_channel), 32'd2);
        chk("err_choose", 32'(channel_choose), 32'd2);

        // Request while busy is ignored
        sw_channel = 3'd1;
        sw_req     = 1'b1;
        tick();
        sw_req = 1'b0;
        tick();
        sw_channel = 3'd3;
        sw_req     = 1'b1;
        tick();
        sw_req = 1'b0;
        chk("busy_choose", 32'(channel_choose), 32'd1);
        chk("busy_err", 32'(sw_err), 32'd0);
        wait_done("busy_done");
        chk("busy_cur", 32'(cur_channel), 32'd1);
        tick();

        // Fill to full, overflow, drain in order
        for (int i = 1; i <= 16; i++) begin
            push_word(16'(i), 1'b1);
            tick();
        end
        dat_wren = 1'b0;
        chk("fill_level", 32'(fifo_level), 32'd16);
        chk("fill_ovf", 32'(overflow), 32'd0);
        chk("fill_head", 32'(out_data), 32'h0001);
        push_word(16'h0011, 1'b0);
        tick();
        dat_wren = 1'b0;
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_level", 32'(fifo_level), 32'd16);
        drain("drain1");
        chk("ovf_sticky", 32'(overflow), 32'd1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        chk("ovf_clr", 32'(overflow), 32'd0);

        // Full with simultaneous push and pop
        for (int i = 1; i <= 16; i++) begin
            push_word(16'h0100 + 16'(i), 1'b1);
            tick();
        end
        push_word(16'hBEEF, 1'b1);
        out_ready = 1'b1;
        tick();
        dat_wren  = 1'b0;
        out_ready = 1'b0;
        chk("full_pp_level", 32'(fifo_level), 32'd16);
        chk("full_pp_ovf", 32'(overflow), 32'd0);
        drain("drain2");

        // One entry with simultaneous push and pop
        push_word(16'h0055, 1'b1);
        tick();
        push_word(16'h0066, 1'b1);
        out_ready = 1'b1;
        tick();
        dat_wren  = 1'b0;
        out_ready = 1'b0;
        chk("one_pp_level", 32'(fifo_level), 32'd1);
        chk("one_pp_head", 32'(out_data), 32'h0066);
        drain("drain3");

        // Pop when empty is a no-op
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("empty_pop_level", 32'(fifo_level), 32'd0);

        // Continuous stream across a switch to channel 3
        out_ready  = 1'b1;
        sw_channel = 3'd3;
        sw_req     = 1'b1;
        push_word(16'h2001, 1'b1);
        for (int j = 1; j <= 12; j++) begin
            tick();
            sw_req = 1'b0;
            if (j < 12)
                push_word(16'h2000 + 16'(j + 1),
                          !(drop_en && (j + 1 >= 4) && (j + 1 <= 8)));
            else
                dat_wren = 1'b0;
        end
        chk("stream_cur", 32'(cur_channel), 32'd3);
        drain("stream");
        chk("stream_ovf", 32'(overflow), 32'd0);

        // Reset during FLAG_HI
        push_word(16'h0077, 1'b1);
        sw_channel = 3'd3;
        sw_req     = 1'b1;
        sw_channel = 3'd1;
        tick();
        sw_req   = 1'b0;
        dat_wren = 1'b0;
        chk("pre_rst_flag", 32'(update_flag), 32'd1);
        chk("pre_rst_level", 32'(fifo_level), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        sb.delete();
        chk("mid_rst_flag", 32'(update_flag), 32'd0);
        chk("mid_rst_choose", 32'(channel_choose), 32'd0);
        chk("mid_rst_level", 32'(fifo_level), 32'd0);
        chk("mid_rst_busy", 32'(sw_busy), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        chk("post_rst_busy", 32'(sw_busy), 32'd0);
        chk("post_rst_cur", 32'(cur_channel), 32'd0);
        sw_channel = 3'd1;
        sw_req     = 1'b1;
        tick();
        sw_req = 1'b0;
        chk("post_rst_flag", 32'(update_flag), 32'd1);
        wait_done("post_rst_done");
        chk("post_rst_cur1", 32'(cur_channel), 32'd1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
